// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: two requester FIFOs drained round-robin onto the
// single write port, with a pending-write scoreboard for hazard detection.
module regfile_write_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       AValid,
  output logic                       AReady,
  input  logic [ADDR_WIDTH-1:0]      AAddr,
  input  logic [DATA_WIDTH-1:0]      AData,
  input  logic                       BValid,
  output logic                       BReady,
  input  logic [ADDR_WIDTH-1:0]      BAddr,
  input  logic [DATA_WIDTH-1:0]      BData,
  output logic                       RegWrite,
  output logic [ADDR_WIDTH-1:0]      WriteRegister,
  output logic [DATA_WIDTH-1:0]      WriteData,
  output logic [(2**ADDR_WIDTH)-1:0] Pending,
  output logic                       Idle
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic {PriA, PriB} pri_e;

  // Index 0 is requester A, index 1 is requester B.
  logic [ADDR_WIDTH-1:0] addr_q   [2][DEPTH];
  logic [DATA_WIDTH-1:0] data_q   [2][DEPTH];
  logic [PtrW-1:0]       rd_ptr_q [2];
  logic [PtrW-1:0]       wr_ptr_q [2];
  logic [CntW-1:0]       count_q  [2];
  pri_e                  pri_q;

  logic [1:0]            in_valid;
  logic [ADDR_WIDTH-1:0] in_addr [2];
  logic [DATA_WIDTH-1:0] in_data [2];
  logic [1:0]            head_valid;
  logic [1:0]            full;
  logic [1:0]            push;
  logic [1:0]            grant;
  logic [PtrW-1:0]       offset;

  assign in_valid   = {BValid, AValid};
  assign in_addr[0] = AAddr;
  assign in_addr[1] = BAddr;
  assign in_data[0] = AData;
  assign in_data[1] = BData;

  // Ready depends on registered occupancy only; a full FIFO refuses even while popping.
  always_comb begin
    head_valid = '0;
    full       = '0;
    push       = '0;
    for (int i = 0; i < 2; i++) begin
      head_valid[i] = count_q[i] != '0;
      full[i]       = count_q[i] == CntW'(DEPTH);
      // Writes to register 0 complete the handshake but are dropped here.
      push[i]       = in_valid[i] & ~full[i] & (in_addr[i] != '0);
    end
  end

  assign AReady = ~full[0];
  assign BReady = ~full[1];
  assign Idle   = ~head_valid[0] & ~head_valid[1];

  always_comb begin
    grant = 2'b00;
    if (pri_q == PriA) begin
      if (head_valid[0])      grant = 2'b01;
      else if (head_valid[1]) grant = 2'b10;
    end else begin
      if (head_valid[1])      grant = 2'b10;
      else if (head_valid[0]) grant = 2'b01;
    end
  end

  always_comb begin
    RegWrite      = 1'b0;
    WriteRegister = '0;
    WriteData     = '0;
    if (grant[0]) begin
      RegWrite      = 1'b1;
      WriteRegister = addr_q[0][rd_ptr_q[0]];
      WriteData     = data_q[0][rd_ptr_q[0]];
    end else if (grant[1]) begin
      RegWrite      = 1'b1;
      WriteRegister = addr_q[1][rd_ptr_q[1]];
      WriteData     = data_q[1][rd_ptr_q[1]];
    end
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    Pending = '0;
    offset  = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        offset = PtrW'(j) - rd_ptr_q[i];
        if (CntW'(offset) < count_q[i]) Pending[addr_q[i][j]] = 1'b1;
      end
    end
    Pending[0] = 1'b0;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 2; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      pri_q <= PriA;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i])  wr_ptr_q[i] <= wr_ptr_q[i] + PtrW'(1);
        if (grant[i]) rd_ptr_q[i] <= rd_ptr_q[i] + PtrW'(1);
        count_q[i] <= count_q[i] + CntW'(push[i]) - CntW'(grant[i]);
      end
      unique case (pri_q)
        PriA: if (grant[0]) pri_q <= PriB;
        PriB: if (grant[1]) pri_q <= PriA;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides which slots are meaningful.
  always_ff @(posedge Clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) begin
        addr_q[i][wr_ptr_q[i]] <= in_addr[i];
        data_q[i][wr_ptr_q[i]] <= in_data[i];
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus random traffic compared each
// cycle against a queue-based model of the two FIFOs and the round-robin priority.
module tb_regfile_write_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          AValid = 1'b0, BValid = 1'b0;
  logic          AReady, BReady;
  logic [AW-1:0] AAddr = '0, BAddr = '0;
  logic [DW-1:0] AData = '0, BData = '0;
  logic          RegWrite;
  logic [AW-1:0] WriteRegister;
  logic [DW-1:0] WriteData;
  logic [31:0]   Pending;
  logic          Idle;

  regfile_write_arbiter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH     (DEPTH)
  ) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .AValid       (AValid),
    .AReady       (AReady),
    .AAddr        (AAddr),
    .AData        (AData),
    .BValid       (BValid),
    .BReady       (BReady),
    .BAddr        (BAddr),
    .BData        (BData),
    .RegWrite     (RegWrite),
    .WriteRegister(WriteRegister),
    .WriteData    (WriteData),
    .Pending      (Pending),
    .Idle         (Idle)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  ent_t qa[$];
  ent_t qb[$];
  bit   pri_b;
  bit   acc_a, acc_b;
  int   total = 0;
  int   bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // 0: no grant, 1: A, 2: B
  function automatic int model_grant();
    bit ha;
    bit hb;
    ha = qa.size() > 0;
    hb = qb.size() > 0;
    if (!pri_b) return ha ? 1 : (hb ? 2 : 0);
    return hb ? 2 : (ha ? 1 : 0);
  endfunction

  task automatic model_edge();
    int g;
    bit ra;
    bit rb;
    g  = model_grant();
    ra = qa.size() < DEPTH;
    rb = qb.size() < DEPTH;
    acc_a = AValid && ra;
    acc_b = BValid && rb;
    if (g == 1) void'(qa.pop_front());
    if (g == 2) void'(qb.pop_front());
    if (!pri_b && g == 1) pri_b = 1'b1;
    else if (pri_b && g == 2) pri_b = 1'b0;
    if (acc_a && AAddr != 0) qa.push_back('{addr: AAddr, data: AData});
    if (acc_b && BAddr != 0) qb.push_back('{addr: BAddr, data: BData});
  endtask

  task automatic check_all(input string ctx);
    int          g;
    logic [31:0] pend;
    ent_t        h;
    g    = model_grant();
    pend = '0;
    foreach (qa[k]) pend[qa[k].addr] = 1'b1;
    foreach (qb[k]) pend[qb[k].addr] = 1'b1;
    h = '{addr: '0, data: '0};
    if (g == 1) h = qa[0];
    if (g == 2) h = qb[0];
    check({ctx, ".we"},    64'(RegWrite),      64'(g != 0));
    check({ctx, ".waddr"}, 64'(WriteRegister), 64'(h.addr));
    check({ctx, ".wdata"}, 64'(WriteData),     64'(h.data));
    check({ctx, ".pend"},  64'(Pending),       64'(pend));
    check({ctx, ".idle"},  64'(Idle),          64'(qa.size() == 0 && qb.size() == 0));
    check({ctx, ".ardy"},  64'(AReady),        64'(qa.size() < DEPTH));
    check({ctx, ".brdy"},  64'(BReady),        64'(qb.size() < DEPTH));
  endtask

  task automatic drive(input bit va, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                       input bit vb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    AValid = va; AAddr = aa; AData = da;
    BValid = vb; BAddr = ab; BData = db;
  endtask

  task automatic step(input string ctx);
    @(posedge Clk);
    model_edge();
    #1;
    check_all(ctx);
  endtask

  // Asserts reset away from the clock edge and checks the outputs respond immediately.
  task automatic do_reset(input string ctx);
    #1;
    Reset_n = 1'b0;
    #1;
    check({ctx, ".rst_we"},   64'(RegWrite), 64'(0));
    check({ctx, ".rst_pend"}, 64'(Pending),  64'(0));
    check({ctx, ".rst_idle"}, 64'(Idle),     64'(1));
    check({ctx, ".rst_ardy"}, 64'(AReady),   64'(1));
    check({ctx, ".rst_brdy"}, 64'(BReady),   64'(1));
    qa.delete();
    qb.delete();
    pri_b = 1'b0;
    drive(0, '0, '0, 0, '0, '0);
    @(negedge Clk);
    Reset_n = 1'b1;
    #1;
    check_all({ctx, ".post"});
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 5) == 0) return AW'($urandom_range(0, 2));
    return AW'($urandom_range(0, 31));
  endfunction

  initial begin
    int a_left, b_left, wcount, first_w, last_w;
    logic [3:0] seq[$];

    pri_b = 1'b0;
    #3;
    check_all("reset");
    @(negedge Clk);
    Reset_n = 1'b1;
    #1;
    check_all("release");

    // Same-address collision under PriA: r7 gets 0x1 then 0x2.
    drive(1, 5'd7, 32'h1, 1, 5'd7, 32'h2);
    step("t6_c1");
    drive(0, '0, '0, 0, '0, '0);
    check("t6.d1", 64'(WriteData), 64'h1);
    check("t6.p1", 64'(Pending[7]), 64'(1));
    step("t6_c2");
    check("t6.d2", 64'(WriteData), 64'h2);
    check("t6.p2", 64'(Pending[7]), 64'(1));
    step("t6_c3");
    check("t6.p3", 64'(Pending[7]), 64'(0));

    // Single write latency.
    drive(1, 5'd5, 32'hDEAD_BEEF, 0, '0, '0);
    step("t2_c1");
    drive(0, '0, '0, 0, '0, '0);
    check("t2.we",   64'(RegWrite), 64'(1));
    check("t2.addr", 64'(WriteRegister), 64'd5);
    check("t2.p5",   64'(Pending[5]), 64'(1));
    step("t2_c2");
    check("t2.p5off", 64'(Pending[5]), 64'(0));

    // Register 0 push is accepted and dropped.
    drive(1, 5'd0, 32'h1234, 0, '0, '0);
    check("t5.ardy", 64'(AReady), 64'(1));
    step("t5_c1");
    drive(0, '0, '0, 0, '0, '0);
    check("t5.we",   64'(RegWrite), 64'(0));
    check("t5.idle", 64'(Idle), 64'(1));
    step("t5_c2");

    // Contention from reset: A,B,A,B,A,B on consecutive cycles.
    do_reset("t3");
    a_left = 3; b_left = 3; wcount = 0; first_w = -1; last_w = -1;
    for (int c = 0; c < 20; c++) begin
      drive(a_left > 0, AW'(10 + a_left), 32'hA000_0000 + 32'(a_left),
            b_left > 0, AW'(20 + b_left), 32'hB000_0000 + 32'(b_left));
      step("t3");
      if (acc_a && a_left > 0) a_left--;
      if (acc_b && b_left > 0) b_left--;
      if (RegWrite) begin
        seq.push_back(WriteData[31:28]);
        if (first_w < 0) first_w = c;
        last_w = c;
        wcount++;
      end
    end
    drive(0, '0, '0, 0, '0, '0);
    check("t3.count", 64'(wcount), 64'd6);
    check("t3.span",  64'(last_w - first_w + 1), 64'd6);
    foreach (seq[k]) check("t3.order", 64'(seq[k]), (k % 2 == 0) ? 64'hA : 64'hB);

    // Random traffic, with a reset in the middle of it.
    for (int c = 0; c < 600; c++) begin
      int pa, pb;
      pa = (c < 300) ? 9 : 5;
      pb = (c < 300) ? 9 : 7;
      drive($urandom_range(0, 9) < pa, rand_addr(), $urandom(),
            $urandom_range(0, 9) < pb, rand_addr(), $urandom());
      step("rand");
      if (c == 250) do_reset("midrst");
    end
    drive(0, '0, '0, 0, '0, '0);
    for (int c = 0; c < 6; c++) step("drain");
    check("final.idle", 64'(Idle), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
